// File: rtl/rtc_clcd_sequencer_if.sv
// Handshake bundle between the sequencer, the DS1302 RTC master and the I2C CLCD master.
interface rtc_clcd_sequencer_if;
    logic [7:0] rtc_addr;
    logic       rtc_valid;
    logic       rtc_busy;
    logic       rtc_done;
    logic [7:0] rtc_rdata;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_valid;
    logic       lcd_busy;
    logic       lcd_done;

    modport master (
        output rtc_addr, rtc_valid,
        input  rtc_busy, rtc_done, rtc_rdata,
        output lcd_data, lcd_rs, lcd_valid,
        input  lcd_busy, lcd_done
    );

    modport slave (
        input  rtc_addr, rtc_valid,
        output rtc_busy, rtc_done, rtc_rdata,
        input  lcd_data, lcd_rs, lcd_valid,
        output lcd_busy, lcd_done
    );
endinterface

// File: rtl/rtc_clcd_sequencer.sv
// Reads NUM_FIELDS BCD time fields from the RTC master, then writes home + "YY/MM/DD hh:mm:ss" to the CLCD.
// Optional macro HANDSHAKE_TIMEOUT_EN adds a per-state watchdog and the sticky error flag.
module rtc_clcd_sequencer #(
    parameter int unsigned NUM_FIELDS     = 6,
    parameter logic [7:0]  HOME_CMD       = 8'h02,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                        clk,
    input  logic                        reset_p,
    input  logic                        start,
    rtc_clcd_sequencer_if.master        bus,
    output logic                        frame_done,
    output logic                        error
);
    localparam int unsigned MAX_FIELDS = 6;
    localparam int unsigned IDX_W      = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RTC_REQ, S_RTC_WAIT, S_LCD_HOME, S_LCD_HI, S_LCD_LO, S_LCD_SEP, S_DONE
    } state_t;

    state_t           r_state, w_state_nx;
    logic [IDX_W-1:0] r_idx, w_idx_nx;
    logic             r_acc, w_acc_nx;
    logic [7:0]       r_buf [MAX_FIELDS];
    logic             w_cap;
    logic [7:0]       w_cap_val;
    logic [7:0]       r_rtc_addr, w_rtc_addr_nx;
    logic             r_rtc_valid, w_rtc_valid_nx;
    logic [7:0]       r_lcd_data, w_lcd_data_nx;
    logic             r_lcd_rs, w_lcd_rs_nx;
    logic             r_lcd_valid, w_lcd_valid_nx;
    logic             r_frame_done, w_frame_done_nx;
    logic             w_in_lcd;

`ifdef HANDSHAKE_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_error;
    logic             w_tmo_hit;
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    function automatic logic [7:0] rtc_addr_of(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0:    return 8'h8D;
            3'd1:    return 8'h89;
            3'd2:    return 8'h87;
            3'd3:    return 8'h85;
            3'd4:    return 8'h83;
            default: return 8'h81;
        endcase
    endfunction

    // Hour drops the 12/24 bit, second drops the clock-halt bit.
    function automatic logic [7:0] mask_of(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd3:    return 8'h3F;
            3'd5:    return 8'h7F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] digit(input logic [3:0] nib);
        return (nib <= 4'd9) ? (8'h30 + {4'h0, nib}) : 8'h3F;
    endfunction

    function automatic logic [7:0] sep_of(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0, 3'd1: return 8'h2F;
            3'd2:       return 8'h20;
            default:    return 8'h3A;
        endcase
    endfunction

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_acc_nx   = r_acc;
        w_cap      = 1'b0;
        w_cap_val  = bus.rtc_rdata & mask_of(r_idx);
`ifdef HANDSHAKE_TIMEOUT_EN
        w_tmo_hit  = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_RTC_REQ;
                    w_idx_nx   = '0;
                end
            end
            S_RTC_REQ: begin
                if (bus.rtc_busy) w_state_nx = S_RTC_WAIT;
            end
            S_RTC_WAIT: begin
                if (bus.rtc_done) begin
                    w_cap = 1'b1;
                    if (r_idx < LAST_IDX) begin
                        w_idx_nx   = r_idx + IDX_W'(1);
                        w_state_nx = S_RTC_REQ;
                    end else begin
                        w_idx_nx   = '0;
                        w_state_nx = S_LCD_HOME;
                    end
                end
            end
            S_LCD_HOME, S_LCD_HI, S_LCD_LO, S_LCD_SEP: begin
                // r_acc marks that the current byte was accepted and we now wait for done.
                if (!r_acc) begin
                    if (bus.lcd_busy) w_acc_nx = 1'b1;
                end else if (bus.lcd_done) begin
                    w_acc_nx = 1'b0;
                    if (r_state == S_LCD_HOME) begin
                        w_state_nx = S_LCD_HI;
                    end else if (r_state == S_LCD_HI) begin
                        w_state_nx = S_LCD_LO;
                    end else if (r_state == S_LCD_LO) begin
                        w_state_nx = (r_idx == LAST_IDX) ? S_DONE : S_LCD_SEP;
                    end else begin
                        w_idx_nx   = r_idx + IDX_W'(1);
                        w_state_nx = S_LCD_HI;
                    end
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase

`ifdef HANDSHAKE_TIMEOUT_EN
        if (r_state != S_IDLE && r_state != S_DONE && w_state_nx == r_state &&
            r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            w_tmo_hit  = 1'b1;
            w_state_nx = S_IDLE;
            w_idx_nx   = '0;
            w_acc_nx   = 1'b0;
        end
`endif

        // Outputs are registered from the next state so they line up with it.
        w_in_lcd        = (w_state_nx == S_LCD_HOME) || (w_state_nx == S_LCD_HI) ||
                          (w_state_nx == S_LCD_LO)   || (w_state_nx == S_LCD_SEP);
        w_rtc_valid_nx  = (w_state_nx == S_RTC_REQ);
        w_rtc_addr_nx   = w_rtc_valid_nx ? rtc_addr_of(w_idx_nx) : 8'h00;
        w_lcd_valid_nx  = w_in_lcd && !w_acc_nx;
        w_lcd_rs_nx     = w_in_lcd && (w_state_nx != S_LCD_HOME);
        w_frame_done_nx = (w_state_nx == S_DONE);
        unique case (w_state_nx)
            S_LCD_HOME: w_lcd_data_nx = HOME_CMD;
            S_LCD_HI:   w_lcd_data_nx = digit(r_buf[w_idx_nx][7:4]);
            S_LCD_LO:   w_lcd_data_nx = digit(r_buf[w_idx_nx][3:0]);
            S_LCD_SEP:  w_lcd_data_nx = sep_of(w_idx_nx);
            default:    w_lcd_data_nx = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_acc        <= 1'b0;
            r_rtc_addr   <= 8'h00;
            r_rtc_valid  <= 1'b0;
            r_lcd_data   <= 8'h00;
            r_lcd_rs     <= 1'b0;
            r_lcd_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < MAX_FIELDS; i++) r_buf[i] <= 8'h00;
        end else begin
            r_state      <= w_state_nx;
            r_idx        <= w_idx_nx;
            r_acc        <= w_acc_nx;
            r_rtc_addr   <= w_rtc_addr_nx;
            r_rtc_valid  <= w_rtc_valid_nx;
            r_lcd_data   <= w_lcd_data_nx;
            r_lcd_rs     <= w_lcd_rs_nx;
            r_lcd_valid  <= w_lcd_valid_nx;
            r_frame_done <= w_frame_done_nx;
            if (w_cap) r_buf[r_idx] <= w_cap_val;
        end
    end

`ifdef HANDSHAKE_TIMEOUT_EN
    // Watchdog counts cycles spent in one busy state; any state change restarts it.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_tmo_cnt <= '0;
            r_error   <= 1'b0;
        end else begin
            if (r_state == S_IDLE || r_state == S_DONE || w_state_nx != r_state)
                r_tmo_cnt <= '0;
            else
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            if (w_tmo_hit) r_error <= 1'b1;
        end
    end
    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    assign bus.rtc_addr  = r_rtc_addr;
    assign bus.rtc_valid = r_rtc_valid;
    assign bus.lcd_data  = r_lcd_data;
    assign bus.lcd_rs    = r_lcd_rs;
    assign bus.lcd_valid = r_lcd_valid;
    assign frame_done    = r_frame_done;
endmodule

// File: tb/tb_rtc_clcd_sequencer.sv
// Directed bench: a 6-field and a 3-field sequencer, each with RTC and LCD responder stubs.
module tb_rtc_clcd_sequencer;
    logic       clk = 1'b0;
    logic       reset_p;
    logic [1:0] start;
    logic [1:0] frame_done_w;
    logic [1:0] error_w;

    rtc_clcd_sequencer_if ifc0 ();
    rtc_clcd_sequencer_if ifc1 ();

    rtc_clcd_sequencer #(
        .NUM_FIELDS(6), .HOME_CMD(8'h02)
`ifdef HANDSHAKE_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) dut6 (
        .clk(clk), .reset_p(reset_p), .start(start[0]), .bus(ifc0),
        .frame_done(frame_done_w[0]), .error(error_w[0])
    );

    rtc_clcd_sequencer #(.NUM_FIELDS(3), .HOME_CMD(8'h02)) dut3 (
        .clk(clk), .reset_p(reset_p), .start(start[1]), .bus(ifc1),
        .frame_done(frame_done_w[1]), .error(error_w[1])
    );

    initial forever #5 clk = ~clk;

    // Stub drive/observe arrays, channel 0 = dut6, channel 1 = dut3
    logic [1:0] rtc_busy_d, rtc_done_d, lcd_busy_d, lcd_done_d, lcd_mute;
    logic [7:0] rtc_rdata_d [2];
    logic [1:0] rtc_valid_w, lcd_valid_w, lcd_rs_w;
    logic [7:0] rtc_addr_w [2];
    logic [7:0] lcd_data_w [2];

    assign ifc0.rtc_busy  = rtc_busy_d[0];
    assign ifc0.rtc_done  = rtc_done_d[0];
    assign ifc0.rtc_rdata = rtc_rdata_d[0];
    assign ifc0.lcd_busy  = lcd_busy_d[0];
    assign ifc0.lcd_done  = lcd_done_d[0];
    assign ifc1.rtc_busy  = rtc_busy_d[1];
    assign ifc1.rtc_done  = rtc_done_d[1];
    assign ifc1.rtc_rdata = rtc_rdata_d[1];
    assign ifc1.lcd_busy  = lcd_busy_d[1];
    assign ifc1.lcd_done  = lcd_done_d[1];
    assign rtc_valid_w    = {ifc1.rtc_valid, ifc0.rtc_valid};
    assign lcd_valid_w    = {ifc1.lcd_valid, ifc0.lcd_valid};
    assign lcd_rs_w       = {ifc1.lcd_rs, ifc0.lcd_rs};
    assign rtc_addr_w[0]  = ifc0.rtc_addr;
    assign rtc_addr_w[1]  = ifc1.rtc_addr;
    assign lcd_data_w[0]  = ifc0.lcd_data;
    assign lcd_data_w[1]  = ifc1.lcd_data;

    logic [7:0] rtc_vals [6];
    logic [7:0] exp_addr [6];
    logic [7:0] addr_q0[$], addr_q1[$];
    logic [8:0] lcd_q0[$], lcd_q1[$];
    int         rph [2];
    int         lph [2];
    int         fd_cnt [2];
    int         n_assert = 0;
    int         n_fail = 0;

    function automatic int fld(input logic [7:0] a);
        case (a)
            8'h8D:   return 0;
            8'h89:   return 1;
            8'h87:   return 2;
            8'h85:   return 3;
            8'h83:   return 4;
            default: return 5;
        endcase
    endfunction

    // Responders: accept one cycle after valid is seen, done two cycles later.
    initial begin
        rtc_busy_d = '0; rtc_done_d = '0; lcd_busy_d = '0; lcd_done_d = '0;
        rtc_rdata_d[0] = '0; rtc_rdata_d[1] = '0;
        fd_cnt[0] = 0; fd_cnt[1] = 0;
        forever begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (reset_p) begin
                    rph[k] = 0; lph[k] = 0;
                    rtc_busy_d[k] = 1'b0; rtc_done_d[k] = 1'b0;
                    lcd_busy_d[k] = 1'b0; lcd_done_d[k] = 1'b0;
                end else begin
                    if (frame_done_w[k]) fd_cnt[k]++;
                    case (rph[k])
                        0: if (rtc_valid_w[k]) begin
                            rtc_busy_d[k]  = 1'b1;
                            rtc_rdata_d[k] = rtc_vals[fld(rtc_addr_w[k])];
                            if (k == 0) addr_q0.push_back(rtc_addr_w[k]);
                            else        addr_q1.push_back(rtc_addr_w[k]);
                            rph[k] = 1;
                        end
                        1: begin rtc_busy_d[k] = 1'b0; rph[k] = 2; end
                        2: begin rtc_done_d[k] = 1'b1; rph[k] = 3; end
                        default: begin rtc_done_d[k] = 1'b0; rph[k] = 0; end
                    endcase
                    case (lph[k])
                        0: if (lcd_valid_w[k] && !lcd_mute[k]) begin
                            lcd_busy_d[k] = 1'b1;
                            if (k == 0) lcd_q0.push_back({lcd_rs_w[k], lcd_data_w[k]});
                            else        lcd_q1.push_back({lcd_rs_w[k], lcd_data_w[k]});
                            lph[k] = 1;
                        end
                        1: begin lcd_busy_d[k] = 1'b0; lph[k] = 2; end
                        2: begin lcd_done_d[k] = 1'b1; lph[k] = 3; end
                        default: begin lcd_done_d[k] = 1'b0; lph[k] = 0; end
                    endcase
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs(input int k);
        if (k == 0)
            return 32'({ifc0.rtc_addr, ifc0.rtc_valid, ifc0.lcd_data, ifc0.lcd_rs,
                        ifc0.lcd_valid, frame_done_w[0], error_w[0]});
        return 32'({ifc1.rtc_addr, ifc1.rtc_valid, ifc1.lcd_data, ifc1.lcd_rs,
                    ifc1.lcd_valid, frame_done_w[1], error_w[1]});
    endfunction

    task automatic set_vals(input logic [7:0] y, mo, d, h, mi, s);
        rtc_vals[0] = y; rtc_vals[1] = mo; rtc_vals[2] = d;
        rtc_vals[3] = h; rtc_vals[4] = mi; rtc_vals[5] = s;
    endtask

    task automatic clear_logs();
        lcd_q0.delete(); lcd_q1.delete(); addr_q0.delete(); addr_q1.delete();
    endtask

    task automatic run_frame(input int k, input int nf);
        int base;
        int cyc;
        base = fd_cnt[k];
        cyc = 0;
        start[k] = 1'b1;
        while (fd_cnt[k] < base + nf && cyc < 3000) begin
            @(posedge clk); #2;
            cyc++;
        end
        start[k] = 1'b0;
        chk("frame_in_budget", 32'(cyc < 3000), 32'd1);
        repeat (4) @(posedge clk);
        #2;
        chk("frame_done_pulses", 32'(fd_cnt[k] - base), 32'(nf));
    endtask

    task automatic check_stream(input int k, input string s, input int nf, input int nrtc);
        logic [8:0] q[$];
        logic [7:0] a[$];
        int fl;
        if (k == 0) begin q = lcd_q0; a = addr_q0; end
        else        begin q = lcd_q1; a = addr_q1; end
        clear_logs();
        fl = s.len() + 1;
        chk("lcd_write_count", 32'(q.size()), 32'(nf * fl));
        chk("rtc_read_count", 32'(a.size()), 32'(nf * nrtc));
        for (int f = 0; f < nf; f++) begin
            for (int i = 0; i < fl; i++) begin
                if (f * fl + i < q.size()) begin
                    if (i == 0) chk("lcd_home", 32'(q[f * fl]), 32'({1'b0, 8'h02}));
                    else        chk("lcd_char", 32'(q[f * fl + i]), 32'({1'b1, s[i - 1]}));
                end
            end
        end
        for (int i = 0; i < a.size() && i < nf * nrtc; i++)
            chk("rtc_addr", 32'(a[i]), 32'(exp_addr[i % nrtc]));
    endtask

    initial begin
        int base;
        int vcyc;
        int cyc;
        exp_addr[0] = 8'h8D; exp_addr[1] = 8'h89; exp_addr[2] = 8'h87;
        exp_addr[3] = 8'h85; exp_addr[4] = 8'h83; exp_addr[5] = 8'h81;
        reset_p = 1'b1;
        start = '0;
        lcd_mute = '0;
        set_vals(8'h23, 8'h10, 8'h11, 8'h19, 8'h41, 8'h36);
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outs_dut6", outs(0), 32'd0);
        chk("reset_outs_dut3", outs(1), 32'd0);
        reset_p = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("idle_no_valid", 32'({rtc_valid_w, lcd_valid_w}), 32'd0);

        run_frame(0, 1);
        check_stream(0, "23/10/11 19:41:36", 1, 6);

        set_vals(8'h23, 8'h1A, 8'h11, 8'hD9, 8'h41, 8'hB6);
        run_frame(0, 1);
        check_stream(0, "23/1?/11 19:41:36", 1, 6);

        set_vals(8'h23, 8'h10, 8'h11, 8'h19, 8'h41, 8'h36);
        run_frame(0, 2);
        check_stream(0, "23/10/11 19:41:36", 2, 6);

        run_frame(1, 1);
        check_stream(1, "23/10/11", 1, 3);

        // Abort a frame mid-flight; outputs must clear before the next edge.
        base = fd_cnt[0];
        start[0] = 1'b1;
        repeat (40) @(posedge clk);
        #3 reset_p = 1'b1;
        #1;
        chk("async_reset_outs", outs(0), 32'd0);
        start[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_p = 1'b0;
        chk("abort_no_frame_done", 32'(fd_cnt[0] - base), 32'd0);
        clear_logs();
        run_frame(0, 1);
        check_stream(0, "23/10/11 19:41:36", 1, 6);

`ifdef HANDSHAKE_TIMEOUT_EN
        lcd_mute[0] = 1'b1;
        base = fd_cnt[0];
        vcyc = 0;
        cyc = 0;
        start[0] = 1'b1;
        @(posedge clk); #2;
        start[0] = 1'b0;
        while (!error_w[0] && cyc < 300) begin
            if (lcd_valid_w[0]) vcyc++;
            @(posedge clk); #2;
            cyc++;
        end
        chk("timeout_error", 32'(error_w[0]), 32'd1);
        chk("timeout_valid_cycles", 32'(vcyc), 32'd16);
        chk("timeout_valids_low", 32'({rtc_valid_w[0], lcd_valid_w[0]}), 32'd0);
        chk("timeout_no_frame_done", 32'(fd_cnt[0] - base), 32'd0);
        lcd_mute[0] = 1'b0;
        clear_logs();
        run_frame(0, 1);
        check_stream(0, "23/10/11 19:41:36", 1, 6);
        chk("error_sticky", 32'(error_w[0]), 32'd1);
`else
        vcyc = 0;
        cyc = 0;
        chk("error_tied_low", 32'(error_w), 32'd0 + 32'(vcyc + cyc));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
